bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Round-robin arbiter that shares one slave-side bus between N_MASTERS requesters.
- Produces a registered one-hot grant vector that drives the one-hot select of the bus datapath mux directly. All-zero grant means the mux outputs 0.
- Holds each grant for a whole transaction, then rotates priority so that no requester starves.

Parameters:
- N_MASTERS, 4: number of requesters; equals the grant width and the datapath mux select width (>= 1).
- TIMEOUT_CYCLES, 255: watchdog limit in cycles; used only when ARB_TIMEOUT_EN is defined (>= 1).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_i  input  N_MASTERS  per-master request level; a master holds it until its transaction completes.
- ack_i  input  1  slave completion strobe, one cycle, for the granted transaction.
- gnt_o  output  N_MASTERS  registered one-hot grant, or all zeros; wired to the mux select.
- gnt_id_o  output  max(1,$clog2(N_MASTERS))  binary index of the granted master; 0 when idle.
- busy_o  output  1  equals |gnt_o.
- timeout_o  output  1  one-cycle pulse on forced release (ARB_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Reset (async assert, sync deassert by clock):
  - gnt_o=0, gnt_id_o=0, busy_o=0, timeout_o=0.
  - State=IDLE; priority pointer ptr=0, so master 0 has highest priority.
  - Reset mid-transaction drops the grant immediately, without waiting for a clock edge.
- States: IDLE (gnt_o=0) and GRANT (exactly one bit of gnt_o set).
- Pick function:
  - Scan req_i starting at index ptr, ascending with wrap-around.
  - The first set bit wins.
  - When it wins, ptr <= winner+1 mod N_MASTERS, so the winner becomes lowest priority.
- IDLE:
  - If req_i != 0 at edge k, gnt_o shows the picked master after edge k, i.e. visible in cycle k+1 (1-cycle latency). State -> GRANT.
  - If req_i == 0, stay in IDLE.
  - ack_i is ignored in IDLE.
- GRANT:
  - gnt_o is stable while the granted master's req bit stays high and ack_i=0. Other req changes have no effect.
  - Release event = ack_i=1, OR the granted master's req bit = 0 (abort).
  - Both conditions in the same cycle count as a single release.
- On release at edge k:
  - Re-pick from the current req_i using the updated ptr, and load the result at edge k (back-to-back grant with no dead cycle).
  - The just-released master may be re-granted only if no other master is requesting.
  - If req_i is zero (ignoring the released master's bit when the release was an abort), gnt_o <= 0 and state -> IDLE.
- gnt_id_o and gnt_o always update on the same edge; busy_o is combinational from gnt_o.
- N_MASTERS=1: ptr is constant 0 and gnt_id_o is 1 bit held at 0.
- Unknown or illegal state encoding recovers to IDLE with gnt_o=0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on every new grant and increments each cycle in GRANT.
  - When it reaches TIMEOUT_CYCLES without a release, force a release at that edge using normal re-pick rules, with the stuck master treated as non-requesting for that pick.
  - timeout_o pulses high for exactly one cycle, aligned with the new gnt_o.
  - ack_i arriving in the same cycle as the timeout takes precedence; no pulse.
- Undefined: no counter is present; timeout_o is tied 0 and TIMEOUT_CYCLES is unused.

Decomposition:
- Shared header arb_defs.vh holds:
  - state encodings ARB_IDLE and ARB_GRANT;
  - a width macro for the index, clog2 with a minimum of 1.
- One natural sub-module: rr_pick, purely combinational.
  - Inputs: req, ptr. Outputs: one-hot winner, binary index, any_valid.
  - Instantiated once inside bus_arbiter.

Test Plan (all with N_MASTERS=4 unless stated):
- Reset then single request: req_i=0100 at edge 1 -> gnt_o=0100 and gnt_id_o=2 from cycle 2. ack_i pulse with req dropped -> gnt_o=0000 next cycle, busy_o=0.
- Round-robin fairness:
  - req_i=1111 held; ack_i every 3rd cycle -> grant order 0001, 0010, 0100, 1000, 0001, each held 3 cycles with no idle gap.
  - Drive ack_i 1 cycle after each new grant -> the same rotation, with each grant held for 2 cycles.
- Abort: master 1 granted, drops req_i[1] with ack_i=0 while req_i[3]=1 -> gnt_o=1000 next cycle. Same-cycle ack plus drop -> exactly one rotation.
- Hold stability: master 0 granted; toggle req_i[3:1] randomly with ack_i=0 for 20 cycles -> gnt_o stays 0001 and no glitches. Async rst_i pulse mid-grant -> gnt_o=0000 before the next edge, and the next grant starts from master 0.
- Sole re-request: only master 2 requesting, ack_i pulses repeatedly -> gnt_o stays 0100 continuously (back-to-back re-grant).
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8: master 0 holds req with no ack, req_i=0011 -> after 8 GRANT cycles gnt_o=0010 with a 1-cycle timeout_o pulse. An ack on cycle 8 -> no pulse.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: FSM encodings and the index-width helper.
package bus_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'b00;
  localparam logic [1:0] ARB_GRANT = 2'b01;

  // Index width is clog2 of the count, but never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin pick: the first set request at or after ptr, with wrap-around.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any_valid
);

  logic [W-1:0] cand [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign cand[gi] = W'((32'(ptr) + gi) % N);
  end

  always_comb begin
    onehot    = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (!any_valid && req[cand[off]]) begin
        any_valid        = 1'b1;
        idx              = cand[off];
        onehot[cand[off]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a registered one-hot grant held for a whole transaction.
// Optional watchdog forced release is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [N_MASTERS-1:0]              req_i,
  input  logic                              ack_i,
  output logic [N_MASTERS-1:0]              gnt_o,
  output logic [idx_width(N_MASTERS)-1:0]   gnt_id_o,
  output logic                              busy_o,
  output logic                              timeout_o
);

  localparam int IW = idx_width(N_MASTERS);

  logic [1:0]           state_reg, state_next;
  logic [N_MASTERS-1:0] gnt_reg, gnt_next;
  logic [IW-1:0]        id_reg, id_next;
  logic [IW-1:0]        ptr_reg, ptr_next;

  logic [N_MASTERS-1:0] pick_req, pick_onehot;
  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;
  logic                 owner_req, release_evt, force_evt;
  logic                 load_pick, go_idle;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          timeout_reg;

  // An ack or an abort in the final cycle is an ordinary release, so no forced one.
  assign force_evt = (state_reg == ARB_GRANT) && owner_req && !ack_i &&
                     (cnt_reg == CW'(TIMEOUT_CYCLES - 1));
`else
  assign force_evt = 1'b0;
`endif

  assign owner_req   = |(req_i & gnt_reg);
  assign release_evt = ack_i || !owner_req || force_evt;
  // A stuck master is excluded from the pick that evicts it.
  assign pick_req    = force_evt ? (req_i & ~gnt_reg) : req_i;

  rr_pick #(
    .N (N_MASTERS),
    .W (IW)
  ) u_pick (
    .req       (pick_req),
    .ptr       (ptr_reg),
    .onehot    (pick_onehot),
    .idx       (pick_idx),
    .any_valid (pick_valid)
  );

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    id_next    = id_reg;
    ptr_next   = ptr_reg;
    load_pick  = 1'b0;
    go_idle    = 1'b0;

    case (state_reg)
      ARB_IDLE: begin
        if (pick_valid) load_pick = 1'b1;
      end
      ARB_GRANT: begin
        if (release_evt) begin
          if (pick_valid) load_pick = 1'b1;
          else            go_idle   = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (load_pick) begin
      state_next = ARB_GRANT;
      gnt_next   = pick_onehot;
      id_next    = pick_idx;
      ptr_next   = (pick_idx == IW'(N_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
    end else if (go_idle) begin
      state_next = ARB_IDLE;
      gnt_next   = '0;
      id_next    = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ARB_IDLE;
      gnt_reg   <= '0;
      id_reg    <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      id_reg    <= id_next;
      ptr_reg   <= ptr_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_comb begin
    cnt_next = cnt_reg;
    if (load_pick)                     cnt_next = '0;
    else if (state_reg == ARB_GRANT)   cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      timeout_reg <= force_evt;
    end
  end

  assign timeout_o = timeout_reg;
`else
  assign timeout_o = 1'b0;
`endif

  assign gnt_o    = gnt_reg;
  assign gnt_id_o = id_reg;
  assign busy_o   = |gnt_reg;

endmodule
